// File: rtl/integ_dump.sv
// integ_dump: integrate-and-dump accumulator over windows of dump_len+1 accepted samples.
// Each completed window presents its sum on dout with a one-cycle dout_vld pulse.
// The ovf output flags a signed overflow anywhere inside that window.
// Optional macro INTEG_DUMP_SAT_EN: the accumulator saturates on overflow.
// When the macro is left undefined, the accumulator wraps modulo 2^OW.
module integ_dump #(
   parameter int IW = 10,
   parameter int OW = 20,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          din_vld,
   input  logic [IW-1:0] din,
   input  logic [CW-1:0] dump_len,
   output logic [OW-1:0] dout,
   output logic          dout_vld,
   output logic          ovf,
   output logic          busy
);

   // The state is fully implied by the sample counter: IDLE when cnt == 0.
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t        state;
   logic [OW-1:0] acc_reg, acc_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] len_q_reg, len_q_next;
   logic          wovf_reg, wovf_next;
   logic [OW-1:0] dout_reg, dout_next;
   logic          ovf_reg, ovf_next;
   logic          dout_vld_reg, dout_vld_next;

   logic [OW-1:0] din_ext, acc_base, sum_raw, sum_fin;
   logic [CW-1:0] len_eff;
   logic          wovf_base, add_ovf, accept, done;

   // Sign-extend the input sample to the accumulator width.
   assign din_ext = {{(OW-IW+1){din[IW-1]}}, din[IW-2:0]};

   // Decode the state from the counter value.
   always_comb begin
      state = (cnt_reg == '0) ? IDLE : ACC;
   end

   // Next-state logic and datapath. The first sample of a window adds onto zero,
   // so a window never inherits the previous window's sum or overflow bit.
   always_comb begin
      accept    = din_vld & ~clr;
      acc_base  = (state == IDLE) ? '0 : acc_reg;
      wovf_base = (state == ACC) & wovf_reg;
      len_eff   = (state == IDLE) ? dump_len : len_q_reg;
      sum_raw   = acc_base + din_ext;
      add_ovf   = (acc_base[OW-1] == din_ext[OW-1]) && (sum_raw[OW-1] != acc_base[OW-1]);
`ifdef INTEG_DUMP_SAT_EN
      // Clamp toward the sign shared by both operands.
      if (add_ovf)
         sum_fin = acc_base[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      else
         sum_fin = sum_raw;
`else
      sum_fin = sum_raw;
`endif
      done = (cnt_reg == len_eff);

      acc_next      = acc_reg;
      cnt_next      = cnt_reg;
      len_q_next    = len_q_reg;
      wovf_next     = wovf_reg;
      dout_next     = dout_reg;
      ovf_next      = ovf_reg;
      dout_vld_next = 1'b0;

      if (clr) begin
         acc_next  = '0;
         cnt_next  = '0;
         wovf_next = 1'b0;
      end else if (accept) begin
         // dump_len is sampled only at window start; later changes are ignored.
         len_q_next = len_eff;
         acc_next   = sum_fin;
         wovf_next  = wovf_base | add_ovf;
         if (done) begin
            cnt_next      = '0;
            dout_next     = sum_fin;
            ovf_next      = wovf_base | add_ovf;
            dout_vld_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   // State register; reset discards any partial window.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_reg      <= '0;
         cnt_reg      <= '0;
         len_q_reg    <= '0;
         wovf_reg     <= 1'b0;
         dout_reg     <= '0;
         ovf_reg      <= 1'b0;
         dout_vld_reg <= 1'b0;
      end else begin
         acc_reg      <= acc_next;
         cnt_reg      <= cnt_next;
         len_q_reg    <= len_q_next;
         wovf_reg     <= wovf_next;
         dout_reg     <= dout_next;
         ovf_reg      <= ovf_next;
         dout_vld_reg <= dout_vld_next;
      end
   end

   assign dout     = dout_reg;
   assign ovf      = ovf_reg;
   assign dout_vld = dout_vld_reg;
   assign busy     = (state == ACC);

endmodule
